imem_loader: RTL

Boot-time writer for the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. It writes the words into the instruction RAM's write port at word-aligned byte addresses, and holds the core in reset until the image is complete. It sits between the host/debug byte link and the instruction RAM, which is read by the fetch path on its combinational `a`/`rd` port.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_packer.sv | 28 ++
 rtl/imem_loader.sv | 99 +++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam int IMEM_DEPTH     = 64;
  localparam int IMEM_ADDR_W    = $clog2(IMEM_DEPTH);
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - 2-bit byte counter and little-endian word assembler
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [31:0] sr;

  // word is the fully assembled value in the cycle the last byte is accepted
  assign word       = {byte_in, sr[31:8]};
  assign word_valid = shift && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sr  <= '0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sr  <= word;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that writes the instruction RAM
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state, state_n;
  logic [AW-1:0]   word_idx, last_idx;
  logic            accept, word_valid, len_ok;
  logic [31:0]     word;
  logic            byte_ready_n, imem_we_n, cpu_hold_n, done_n, err_n;
  logic [31:0]     imem_a_n, imem_wd_n;

  assign accept = byte_valid && byte_ready;
  assign len_ok = (word != 32'd0) && (word <= 32'(DEPTH));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .shift      (accept),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      last_idx   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_a     <= '0;
      imem_wd    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      byte_ready <= byte_ready_n;
      imem_we    <= imem_we_n;
      imem_a     <= imem_a_n;
      imem_wd    <= imem_wd_n;
      cpu_hold   <= cpu_hold_n;
      done       <= done_n;
      err        <= err_n;
      // last_idx holds N-1 so the final-word test needs no wider compare
      if (state == S_LEN && word_valid && len_ok) begin
        last_idx <= AW'(word - 32'd1);
        word_idx <= '0;
      end else if (state == S_WRITE && state_n == S_DATA) begin
        word_idx <= word_idx + AW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LEN;
      S_LEN:   if (word_valid) state_n = len_ok ? S_DATA : S_ERR;
      S_DATA:  if (word_valid) state_n = S_WRITE;
      S_WRITE: state_n = (word_idx == last_idx) ? S_DONE : S_DATA;
      S_DONE:  if (start) state_n = S_LEN;
      S_ERR:   if (start) state_n = S_LEN;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop
  always_comb begin
    byte_ready_n = (state_n == S_LEN) || (state_n == S_DATA);
    imem_we_n    = (state_n == S_WRITE);
    imem_a_n     = imem_a;
    imem_wd_n    = imem_wd;
    if (state_n == S_WRITE) begin
      imem_a_n  = 32'({word_idx, 2'b00});
      imem_wd_n = word;
    end
    cpu_hold_n = (state_n != S_DONE);
    done_n     = (state_n == S_DONE);
    err_n      = (state_n == S_ERR);
  end
endmodule
